// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b control types.
// Holds the opcode and ALU-op enums, the indirect-access FSM states and
// the control word that travels down the control pipe. It also holds
// ctrl_default, the word used for bubbles, reset and unknown opcodes.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000, op_add  = 4'b0001, op_ldb = 4'b0010, op_stb = 4'b0011,
    op_jsr  = 4'b0100, op_and  = 4'b0101, op_ldr = 4'b0110, op_str = 4'b0111,
    op_rti  = 4'b1000, op_not  = 4'b1001, op_ldi = 4'b1010, op_sti = 4'b1011,
    op_jmp  = 4'b1100, op_shf  = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    alu_add  = 2'b00,
    alu_and  = 2'b01,
    alu_not  = 2'b10,
    alu_pass = 2'b11
  } lc3b_aluop;

  typedef enum logic [1:0] {
    IND_IDLE = 2'b00,
    IND_ADDR = 2'b01,
    IND_DATA = 2'b10
  } lc3b_ind_state;

  typedef struct packed {
    lc3b_opcode opcode;
    lc3b_aluop  aluop;
    logic [2:0] nzp;             // BR condition mask
    logic [1:0] alumux_sel;      // 00 sr2, 01 offset6, 10 imm5
    logic [1:0] regfilemux_sel;  // 00 alu, 01 memory data
    logic [1:0] pcmux_sel;       // 00 pc+2, 01 branch target
    logic       indirectmux_sel; // 0 computed address, 1 pointer from memory
    logic       is_indirect;     // LDI/STI
    logic       load_regfile;
    logic       load_cc;
    logic       load_pc;
    logic       dmem_read;
    logic       dmem_write;
  } lc3b_control_word;

  localparam lc3b_control_word ctrl_default = '{
    opcode: op_br, aluop: alu_add, nzp: 3'b000,
    alumux_sel: 2'b00, regfilemux_sel: 2'b00, pcmux_sel: 2'b00,
    indirectmux_sel: 1'b0, is_indirect: 1'b0,
    load_regfile: 1'b0, load_cc: 1'b0, load_pc: 1'b0,
    dmem_read: 1'b0, dmem_write: 1'b0
  };

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction -> control word.
//   ir   in  16  instruction in decode
//   ctrl out     decoded control word (ctrl_default for unknown opcodes)
module ctrl_decode
  import lc3b_types::*;
(
  input  logic [15:0]      ir,
  output lc3b_control_word ctrl
);

  lc3b_opcode opcode_s;
  logic       ir_unused_s;

  assign opcode_s    = lc3b_opcode'(ir[15:12]);
  // Register numbers and offsets are consumed by the datapath, not here.
  assign ir_unused_s = ^{ir[8:6], ir[4:0]};

  // Opcode decode
  always_comb begin
    ctrl = ctrl_default;
    case (opcode_s)
      op_add, op_and: begin
        ctrl.opcode       = opcode_s;
        ctrl.aluop        = (opcode_s == op_and) ? alu_and : alu_add;
        ctrl.alumux_sel   = ir[5] ? 2'b10 : 2'b00;
        ctrl.load_regfile = 1'b1;
        ctrl.load_cc      = 1'b1;
      end
      op_not: begin
        ctrl.opcode       = opcode_s;
        ctrl.aluop        = alu_not;
        ctrl.load_regfile = 1'b1;
        ctrl.load_cc      = 1'b1;
      end
      op_ldr, op_ldi: begin
        ctrl.opcode         = opcode_s;
        ctrl.aluop          = alu_add;
        ctrl.alumux_sel     = 2'b01;
        ctrl.regfilemux_sel = 2'b01;
        ctrl.load_regfile   = 1'b1;
        ctrl.load_cc        = 1'b1;
        ctrl.dmem_read      = 1'b1;
        ctrl.is_indirect    = (opcode_s == op_ldi);
      end
      op_str, op_sti: begin
        ctrl.opcode      = opcode_s;
        ctrl.aluop       = alu_add;
        ctrl.alumux_sel  = 2'b01;
        ctrl.dmem_write  = 1'b1;
        ctrl.is_indirect = (opcode_s == op_sti);
      end
      op_br: begin
        ctrl.opcode    = opcode_s;
        ctrl.nzp       = ir[11:9];
        ctrl.pcmux_sel = 2'b01;
      end
      default: ctrl = ctrl_default;
    endcase
  end

endmodule

// File: rtl/lc3b_ctrl_pipe.sv
// lc3b_ctrl_pipe: decoded control word carried through N_STAGES stage
// registers (index 0 = EX) with valid bits, global stall, branch flush and
// the two-access indirect FSM for LDI/STI.
//   clk, reset     clock, synchronous active-high reset
//   ir, ir_valid   instruction in decode and its valid flag
//   branch_enable  CC match for the BR sitting in BR_STAGE
//   dmem_resp      data-memory access completes this cycle
//   ctrl_out       per-stage control word, load/dmem bits gated by valid
//   valid_out      per-stage valid
//   stall_out      freeze fetch/decode and all stage registers
//   flush_out      branch taken: redirect fetch, squash younger stages
module lc3b_ctrl_pipe
  import lc3b_types::*;
#(
  parameter int N_STAGES  = 3,
  parameter int MEM_STAGE = 1,
  parameter int BR_STAGE  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [15:0]                          ir,
  input  logic                                 ir_valid,
  input  logic                                 branch_enable,
  input  logic                                 dmem_resp,
  output lc3b_control_word [N_STAGES-1:0]      ctrl_out,
  output logic             [N_STAGES-1:0]      valid_out,
  output logic                                 stall_out,
  output logic                                 flush_out
);

  lc3b_control_word                 dec_word_s;
  lc3b_control_word [N_STAGES-1:0]  stage_r;
  lc3b_control_word [N_STAGES-1:0]  ctrl_s;
  logic             [N_STAGES-1:0]  valid_r;
  lc3b_ind_state                    ind_state_r;
  lc3b_control_word                 mem_word_s;
  lc3b_control_word                 br_word_s;
  logic mem_valid_s, ind_word_s, mem_wait_s, ind_busy_s, stall_s, flush_s;
  logic ind_rd_s, ind_wr_s, ind_mux_s;

  ctrl_decode u_decode (
    .ir   (ir),
    .ctrl (dec_word_s)
  );

  assign mem_word_s  = stage_r[MEM_STAGE];
  assign mem_valid_s = valid_r[MEM_STAGE];
  assign br_word_s   = stage_r[BR_STAGE];
  assign ind_word_s  = mem_valid_s & mem_word_s.is_indirect;

  assign mem_wait_s = mem_valid_s & (mem_word_s.dmem_read | mem_word_s.dmem_write)
                    & ~dmem_resp & (ind_state_r == IND_IDLE) & ~mem_word_s.is_indirect;

  // A BR with nzp=000 can never be taken, whatever branch_enable says.
  assign flush_s = valid_r[BR_STAGE] & (br_word_s.opcode == op_br)
                 & (br_word_s.nzp != 3'b000) & branch_enable;

  assign stall_s   = mem_wait_s | ind_busy_s;
  assign stall_out = stall_s;
  assign flush_out = flush_s;
  assign valid_out = valid_r;
  assign ctrl_out  = ctrl_s;

  // Indirect FSM: memory-field override for the MEM-stage word and busy flag
  always_comb begin
    ind_rd_s   = 1'b0;
    ind_wr_s   = 1'b0;
    ind_mux_s  = 1'b0;
    ind_busy_s = 1'b0;
    case (ind_state_r)
      // The cycle an indirect word arrives it holds the pipe while the
      // FSM arms; no memory access is issued yet.
      IND_IDLE: ind_busy_s = ind_word_s;
      IND_ADDR: begin
        ind_rd_s   = 1'b1;
        ind_busy_s = 1'b1;
      end
      IND_DATA: begin
        ind_rd_s   = mem_word_s.dmem_read;
        ind_wr_s   = mem_word_s.dmem_write;
        ind_mux_s  = 1'b1;
        ind_busy_s = ~dmem_resp;
      end
      default: ind_busy_s = 1'b0;
    endcase
  end

  // Per-stage output words: FSM override, taken-branch load_pc, valid gating
  always_comb begin
    ctrl_s = stage_r;
    for (int k = 0; k < N_STAGES; k++) begin
      ctrl_s[k].dmem_read = (((k == MEM_STAGE) && stage_r[k].is_indirect) ?
                             ind_rd_s : stage_r[k].dmem_read) & valid_r[k];
      ctrl_s[k].dmem_write = (((k == MEM_STAGE) && stage_r[k].is_indirect) ?
                              ind_wr_s : stage_r[k].dmem_write) & valid_r[k];
      ctrl_s[k].indirectmux_sel = ((k == MEM_STAGE) && stage_r[k].is_indirect) ?
                                  ind_mux_s : stage_r[k].indirectmux_sel;
      ctrl_s[k].load_pc = (stage_r[k].load_pc | ((k == BR_STAGE) & flush_s))
                          & valid_r[k];
      ctrl_s[k].load_regfile = stage_r[k].load_regfile & valid_r[k];
      ctrl_s[k].load_cc      = stage_r[k].load_cc & valid_r[k];
    end
  end

  // Stage registers and indirect FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_STAGES; k++) begin
        stage_r[k] <= ctrl_default;
      end
      valid_r     <= {N_STAGES{1'b0}};
      ind_state_r <= IND_IDLE;
    end else begin
      if (!stall_s) begin
        stage_r[0] <= dec_word_s;
        valid_r[0] <= ir_valid & ~flush_s;
        for (int k = 1; k < N_STAGES; k++) begin
          stage_r[k] <= stage_r[k-1];
          // Stages up to and including the BR slot are younger than the
          // branch (or the branch itself moving out) and get squashed.
          valid_r[k] <= valid_r[k-1] & ~(flush_s & (k <= BR_STAGE));
        end
      end else begin
        stage_r <= stage_r;
        valid_r <= valid_r;
      end
      case (ind_state_r)
        IND_IDLE: ind_state_r <= ind_word_s ? IND_ADDR : IND_IDLE;
        IND_ADDR: ind_state_r <= dmem_resp ? IND_DATA : IND_ADDR;
        IND_DATA: ind_state_r <= dmem_resp ? IND_IDLE : IND_DATA;
        default:  ind_state_r <= IND_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
// Testbench for lc3b_ctrl_pipe: decode table, hand-written sequences for
// branch/stall/indirect/reset corner cases, then random traffic checked
// against a slot-level reference model.
module tb_lc3b_ctrl_pipe;
  import lc3b_types::*;

  localparam int NS = 3;
  localparam int MS = 1;
  localparam int BS = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] ir = 16'h0000;
  logic ir_valid = 1'b0, branch_enable = 1'b0, dmem_resp = 1'b0;
  lc3b_control_word [NS-1:0] ctrl_out;
  logic [NS-1:0] valid_out;
  logic stall_out, flush_out;

  always #5 clk = ~clk;

  lc3b_ctrl_pipe #(.N_STAGES(NS), .MEM_STAGE(MS), .BR_STAGE(BS)) dut (
    .clk(clk), .reset(reset), .ir(ir), .ir_valid(ir_valid),
    .branch_enable(branch_enable), .dmem_resp(dmem_resp),
    .ctrl_out(ctrl_out), .valid_out(valid_out),
    .stall_out(stall_out), .flush_out(flush_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: one decoded word + valid per slot, plus indirect progress
  lc3b_control_word m_w [NS];
  logic [NS-1:0] m_v;
  logic m_started = 1'b0;
  int   m_done = 0;
  logic m_ok = 1'b0;

  lc3b_control_word [NS-1:0] o_ctrl;
  logic [NS-1:0] o_valid;
  logic o_stall, o_flush;
  int stall_cnt, flush_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic lc3b_control_word spec_default();
    lc3b_control_word w;
    w = '0;
    w.aluop = alu_add;
    return w;
  endfunction

  function automatic lc3b_control_word spec_decode(input logic [15:0] i);
    lc3b_control_word w;
    logic [3:0] op;
    logic is_load, is_store, is_alu;
    w = spec_default();
    op = i[15:12];
    is_load  = (op == 4'h6) || (op == 4'hA);
    is_store = (op == 4'h7) || (op == 4'hB);
    is_alu   = (op == 4'h1) || (op == 4'h5) || (op == 4'h9);
    if (is_alu || is_load || is_store || op == 4'h0) w.opcode = lc3b_opcode'(op);
    if (is_alu) begin
      w.aluop = (op == 4'h5) ? alu_and : (op == 4'h9) ? alu_not : alu_add;
      w.alumux_sel = (op != 4'h9 && i[5]) ? 2'b10 : 2'b00;
      w.load_regfile = 1'b1;
      w.load_cc = 1'b1;
    end
    if (is_load || is_store) begin
      w.alumux_sel = 2'b01;
      w.is_indirect = (op >= 4'hA);
    end
    if (is_load) begin
      w.regfilemux_sel = 2'b01;
      w.load_regfile = 1'b1;
      w.load_cc = 1'b1;
      w.dmem_read = 1'b1;
    end
    if (is_store) w.dmem_write = 1'b1;
    if (op == 4'h0) begin
      w.nzp = i[11:9];
      w.pcmux_sel = 2'b01;
    end
    return w;
  endfunction

  function automatic logic m_taken();
    return m_v[BS] && m_w[BS].opcode == op_br && m_w[BS].nzp != 3'b000 && branch_enable;
  endfunction

  function automatic logic m_stall();
    if (m_v[MS] && m_w[MS].is_indirect) return !(m_started && m_done == 1 && dmem_resp);
    return m_v[MS] && (m_w[MS].dmem_read || m_w[MS].dmem_write) && !dmem_resp;
  endfunction

  task automatic check_model();
    lc3b_control_word e;
    chk("model valid", o_valid, m_v);
    chk("model stall", o_stall, m_stall());
    chk("model flush", o_flush, m_taken());
    for (int k = 0; k < NS; k++) begin
      e = m_w[k];
      if (k == MS && e.is_indirect) begin
        e.dmem_read = m_started && (m_done == 0 || e.opcode == op_ldi);
        e.dmem_write = m_started && m_done == 1 && e.opcode == op_sti;
        e.indirectmux_sel = m_started && m_done == 1;
      end
      if (k == BS && m_taken()) e.load_pc = 1'b1;
      if (!m_v[k]) begin
        e.load_regfile = 1'b0; e.load_cc = 1'b0; e.load_pc = 1'b0;
        e.dmem_read = 1'b0; e.dmem_write = 1'b0;
      end
      chk($sformatf("model ctrl[%0d]", k), o_ctrl[k], e);
    end
  endtask

  task automatic model_step();
    logic st, fl;
    if (reset) begin
      for (int k = 0; k < NS; k++) m_w[k] = spec_default();
      m_v = '0;
      m_started = 1'b0;
      m_done = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      st = m_stall();
      fl = m_taken();
      if (m_v[MS] && m_w[MS].is_indirect) begin
        if (!m_started) m_started = 1'b1;
        else if (dmem_resp) begin
          if (m_done == 1) begin m_started = 1'b0; m_done = 0; end
          else m_done = 1;
        end
      end
      if (!st) begin
        for (int k = NS - 1; k >= 1; k--) begin
          m_w[k] = m_w[k-1];
          m_v[k] = m_v[k-1] && !(fl && k <= BS);
        end
        m_w[0] = spec_decode(ir);
        m_v[0] = ir_valid && !fl;
      end
    end
  endtask

  // one clock: drive at negedge, sample and check 1 time unit later, step model at posedge
  task automatic cycle(input logic rst, input logic [15:0] i_ir, input logic i_v,
                       input logic be, input logic resp);
    @(negedge clk);
    reset = rst; ir = i_ir; ir_valid = i_v; branch_enable = be; dmem_resp = resp;
    #1;
    o_ctrl = ctrl_out; o_valid = valid_out; o_stall = stall_out; o_flush = flush_out;
    if (o_stall === 1'b1) stall_cnt++;
    if (o_flush === 1'b1) flush_cnt++;
    if (m_ok) check_model();
    @(posedge clk);
    model_step();
  endtask

  typedef struct {
    logic [15:0] ir;
    logic [1:0]  alumux;
    logic [1:0]  rfmux;
    lc3b_aluop   aluop;
    logic [4:0]  loads;  // {regfile, cc, pc, dmem_read, dmem_write}
    logic        ind;
  } dec_vec_t;

  dec_vec_t tbl [10];
  logic [3:0] ops [10];
  lc3b_control_word snap;
  logic [15:0] w16;

  initial begin
    tbl[0] = '{16'h12A3, 2'b10, 2'b00, alu_add, 5'b11000, 1'b0};
    tbl[1] = '{16'h1283, 2'b00, 2'b00, alu_add, 5'b11000, 1'b0};
    tbl[2] = '{16'h5AA5, 2'b10, 2'b00, alu_and, 5'b11000, 1'b0};
    tbl[3] = '{16'h9B3F, 2'b00, 2'b00, alu_not, 5'b11000, 1'b0};
    tbl[4] = '{16'h6701, 2'b01, 2'b01, alu_add, 5'b11010, 1'b0};
    tbl[5] = '{16'h7701, 2'b01, 2'b00, alu_add, 5'b00001, 1'b0};
    tbl[6] = '{16'hA701, 2'b01, 2'b01, alu_add, 5'b11010, 1'b1};
    tbl[7] = '{16'hB701, 2'b01, 2'b00, alu_add, 5'b00001, 1'b1};
    tbl[8] = '{16'h0E02, 2'b00, 2'b00, alu_add, 5'b00000, 1'b0};
    tbl[9] = '{16'hD123, 2'b00, 2'b00, alu_add, 5'b00000, 1'b0};

    // decode table: each vector alone, seen in EX one cycle after decode
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, tbl[i].ir, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk($sformatf("dec %h valid", tbl[i].ir), o_valid, 3'b001);
      chk($sformatf("dec %h alumux", tbl[i].ir), o_ctrl[0].alumux_sel, tbl[i].alumux);
      chk($sformatf("dec %h rfmux", tbl[i].ir), o_ctrl[0].regfilemux_sel, tbl[i].rfmux);
      chk($sformatf("dec %h aluop", tbl[i].ir), o_ctrl[0].aluop, tbl[i].aluop);
      chk($sformatf("dec %h loads", tbl[i].ir),
          {o_ctrl[0].load_regfile, o_ctrl[0].load_cc, o_ctrl[0].load_pc,
           o_ctrl[0].dmem_read, o_ctrl[0].dmem_write}, tbl[i].loads);
      chk($sformatf("dec %h ind", tbl[i].ir), o_ctrl[0].is_indirect, tbl[i].ind);
    end
    chk("unknown opcode field", o_ctrl[0].opcode, op_br);

    // ADD progression
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h12A3, 1'b1, 1'b0, 1'b0);
    chk("reset valid", o_valid, 3'b000);
    chk("reset stall", o_stall, 1'b0);
    chk("reset flush", o_flush, 1'b0);
    cycle(1'b0, 16'h12A3, 1'b1, 1'b0, 1'b0);
    chk("add valid1", o_valid, 3'b001);
    chk("add ex alumux", o_ctrl[0].alumux_sel, 2'b10);
    chk("add ex aluop", o_ctrl[0].aluop, alu_add);
    chk("add ex load_rf", o_ctrl[0].load_regfile, 1'b1);
    cycle(1'b0, 16'h12A3, 1'b1, 1'b0, 1'b0);
    chk("add valid2", o_valid, 3'b011);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("add valid3", o_valid, 3'b111);
    chk("add wb load_rf", o_ctrl[2].load_regfile, 1'b1);

    // taken BR flushes once; nzp=000 never flushes
    for (int b = 0; b < 2; b++) begin
      w16 = (b == 0) ? 16'h0E02 : 16'h0000;
      cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
      flush_cnt = 0;
      cycle(1'b0, w16, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 16'h12A3, 1'b1, 1'b1, 1'b0);
      chk("br valid ex", o_valid, 3'b001);
      cycle(1'b0, 16'h12A3, 1'b1, 1'b1, 1'b0);
      chk("br flush", o_flush, (b == 0) ? 1'b1 : 1'b0);
      chk("br load_pc", o_ctrl[1].load_pc, (b == 0) ? 1'b1 : 1'b0);
      cycle(1'b0, 16'h12A3, 1'b1, 1'b1, 1'b0);
      chk("br valid after", o_valid, (b == 0) ? 3'b100 : 3'b111);
      chk("br wb load_pc", o_ctrl[2].load_pc, 1'b0);
      chk("br flush count", flush_cnt, (b == 0) ? 1 : 0);
    end

    // LDR waits three cycles for memory
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    stall_cnt = 0;
    cycle(1'b0, 16'h6701, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("ldr stall before mem", o_stall, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    snap = o_ctrl[1];
    chk("ldr mem read", o_ctrl[1].dmem_read, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("ldr held word", o_ctrl[1], snap);
    chk("ldr held valid", o_valid, 3'b010);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("ldr resp stall", o_stall, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("ldr advanced", o_valid, 3'b100);
    chk("ldr stall count", stall_cnt, 3);

    // LDI / STI two-access sequence
    for (int s = 0; s < 2; s++) begin
      w16 = (s == 0) ? 16'hA701 : 16'hB701;
      cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
      stall_cnt = 0;
      cycle(1'b0, w16, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("ind arm stall", o_stall, 1'b1);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("ind addr read", o_ctrl[1].dmem_read, 1'b1);
      chk("ind addr mux", o_ctrl[1].indirectmux_sel, 1'b0);
      chk("ind addr write", o_ctrl[1].dmem_write, 1'b0);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("ind addr resp stall", o_stall, 1'b1);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("ind data mux", o_ctrl[1].indirectmux_sel, 1'b1);
      chk("ind data read", o_ctrl[1].dmem_read, (s == 0) ? 1'b1 : 1'b0);
      chk("ind data write", o_ctrl[1].dmem_write, (s == 0) ? 1'b0 : 1'b1);
      chk("ind data resp stall", o_stall, 1'b0);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("ind wb valid", o_valid, 3'b100);
      chk("ind wb load_rf", o_ctrl[2].load_regfile, (s == 0) ? 1'b1 : 1'b0);
      chk("ind wb rfmux", o_ctrl[2].regfilemux_sel, (s == 0) ? 2'b01 : 2'b00);
      chk("ind stall count", stall_cnt, 3);
    end

    // reset in the middle of the data access
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'hA701, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("mid data mux", o_ctrl[1].indirectmux_sel, 1'b1);
    chk("mid data stall", o_stall, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("midrst valid", o_valid, 3'b000);
    chk("midrst stall", o_stall, 1'b0);
    chk("midrst flush", o_flush, 1'b0);
    for (int k = 0; k < NS; k++)
      chk($sformatf("midrst loads[%0d]", k),
          {o_ctrl[k].load_regfile, o_ctrl[k].load_cc, o_ctrl[k].load_pc,
           o_ctrl[k].dmem_read, o_ctrl[k].dmem_write}, 5'b00000);
    chk("midrst mux", o_ctrl[1].indirectmux_sel, 1'b0);

    // random traffic against the model
    ops = '{4'h0, 4'h1, 4'h5, 4'h9, 4'h6, 4'h7, 4'hA, 4'hB, 4'hD, 4'h0};
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      w16 = {ops[$urandom_range(0, 9)], 12'($urandom)};
      cycle(($urandom_range(0, 299) == 0), w16, ($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
